// File: rtl/qn_toggle_monitor.sv
// Per-bit toggle counter for negedge-launched QN lines, sampled on the rising CLK edge.
// Optional macro QN_TOGGLE_MON_TOTAL_EN adds a TOTAL output summing every per-bit increment.
module qn_toggle_monitor #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16,
  parameter int WIN_W = 16,
  localparam int SEL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             CLK,
  input  logic             RSTB,
  input  logic [WIDTH-1:0] QN_IN,
  input  logic             START,
  input  logic             ABORT,
  input  logic [WIN_W-1:0] WINDOW,
  output logic             BUSY,
  output logic             DONE,
  input  logic [SEL_W-1:0] RD_SEL,
  output logic [CNT_W-1:0] RD_DATA,
  output logic [WIDTH-1:0] SAT
`ifdef QN_TOGGLE_MON_TOTAL_EN
  ,
  output logic [CNT_W+SEL_W-1:0] TOTAL
`endif
);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_COUNT, S_HOLD} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  state_t           r_state;
  state_t           w_state_next;
  logic             w_done_next;
  logic             r_done;
  logic [WIN_W-1:0] r_wcnt;
  logic [WIDTH-1:0] r_prev;
  logic [CNT_W-1:0] r_cnt [WIDTH];
  logic [WIDTH-1:0] r_sat;
  logic [CNT_W-1:0] r_rd_data;
  logic [WIDTH-1:0] w_tog;
  logic [WIDTH-1:0] w_inc;
  logic [WIDTH-1:0] w_sat_hit;
  logic             w_start_acc;
  logic             w_clr;
  logic             w_count;
  logic [CNT_W-1:0] w_cnt_pad [2**SEL_W];

  assign w_start_acc = ((r_state == S_IDLE) || (r_state == S_HOLD)) && START && !ABORT;
  assign w_clr       = (r_state == S_ARM) || ((r_state == S_COUNT) && ABORT);
  assign w_count     = (r_state == S_COUNT) && !ABORT;

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_state <= S_IDLE;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_done  <= w_done_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!ABORT && START) w_state_next = S_ARM;
      end
      S_ARM: begin
        if (ABORT) begin
          w_state_next = S_IDLE;
        end else if (r_wcnt == '0) begin
          w_state_next = S_HOLD;
          w_done_next  = 1'b1;
        end else begin
          w_state_next = S_COUNT;
        end
      end
      S_COUNT: begin
        if (ABORT) begin
          w_state_next = S_IDLE;
        end else if (r_wcnt == WIN_W'(1)) begin
          w_state_next = S_HOLD;
          w_done_next  = 1'b1;
        end
      end
      S_HOLD: begin
        if (ABORT)      w_state_next = S_IDLE;
        else if (START) w_state_next = S_ARM;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // An X/Z on either side makes w_tog unknown, which the if below treats as no toggle.
  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_tog
      assign w_tog[gi] = QN_IN[gi] ^ r_prev[gi];
    end
    for (gi = 0; gi < 2**SEL_W; gi++) begin : g_pad
      if (gi < WIDTH) begin : g_live
        assign w_cnt_pad[gi] = r_cnt[gi];
      end else begin : g_zero
        assign w_cnt_pad[gi] = '0;
      end
    end
  endgenerate

  always_comb begin
    w_inc     = '0;
    w_sat_hit = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (w_count && w_tog[i]) begin
        if (r_cnt[i] == CNT_MAX) w_sat_hit[i] = 1'b1;
        else                     w_inc[i]     = 1'b1;
      end
    end
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      r_prev <= '0;
      r_wcnt <= '0;
    end else begin
      if ((r_state == S_ARM) || w_count) r_prev <= QN_IN;
      if (w_start_acc)  r_wcnt <= WINDOW;
      else if (w_count) r_wcnt <= r_wcnt - WIN_W'(1);
    end
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) begin
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
      r_sat <= '0;
    end else if (w_clr) begin
      for (int i = 0; i < WIDTH; i++) r_cnt[i] <= '0;
      r_sat <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        if (w_inc[i]) r_cnt[i] <= r_cnt[i] + CNT_W'(1);
      end
      r_sat <= r_sat | w_sat_hit;
    end
  end

  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB) r_rd_data <= '0;
    else       r_rd_data <= w_cnt_pad[RD_SEL];
  end

`ifdef QN_TOGGLE_MON_TOTAL_EN
  logic [CNT_W+SEL_W-1:0] r_total;
  logic [SEL_W:0]         w_inc_sum;

  always_comb begin
    w_inc_sum = '0;
    for (int i = 0; i < WIDTH; i++) w_inc_sum = w_inc_sum + (SEL_W+1)'(w_inc[i]);
  end

  // Per-bit counters saturate, so this sum can never exceed its width.
  always_ff @(posedge CLK or negedge RSTB) begin
    if (!RSTB)     r_total <= '0;
    else if (w_clr) r_total <= '0;
    else           r_total <= r_total + (CNT_W+SEL_W)'(w_inc_sum);
  end

  assign TOTAL = r_total;
`endif

  assign BUSY    = (r_state == S_ARM) || (r_state == S_COUNT);
  assign DONE    = r_done;
  assign RD_DATA = r_rd_data;
  assign SAT     = r_sat;

endmodule

// File: tb/tb_qn_toggle_monitor.sv
// Scoreboard bench for qn_toggle_monitor: a 16-bit-counter instance and a 4-bit-counter instance share stimulus.
// Reads and per-scenario BUSY/DONE tallies are queued by the stimulus and checked by a separate monitor.
module tb_qn_toggle_monitor;

  logic        CLK = 1'b0;
  logic        RSTB;
  logic [7:0]  QN_IN;
  logic        START;
  logic        ABORT;
  logic [15:0] WINDOW;
  logic [2:0]  RD_SEL;

  logic        busy_a, done_a, busy_b, done_b;
  logic [15:0] rd_a;
  logic [3:0]  rd_b;
  logic [7:0]  sat_a, sat_b;
`ifdef QN_TOGGLE_MON_TOTAL_EN
  logic [18:0] total_a;
  logic [6:0]  total_b;
`endif

  always #5 CLK = ~CLK;

  qn_toggle_monitor #(.WIDTH(8), .CNT_W(16), .WIN_W(16)) u_dut_a (
    .CLK(CLK), .RSTB(RSTB), .QN_IN(QN_IN), .START(START), .ABORT(ABORT),
    .WINDOW(WINDOW), .BUSY(busy_a), .DONE(done_a), .RD_SEL(RD_SEL),
    .RD_DATA(rd_a), .SAT(sat_a)
`ifdef QN_TOGGLE_MON_TOTAL_EN
    , .TOTAL(total_a)
`endif
  );

  qn_toggle_monitor #(.WIDTH(8), .CNT_W(4), .WIN_W(16)) u_dut_b (
    .CLK(CLK), .RSTB(RSTB), .QN_IN(QN_IN), .START(START), .ABORT(ABORT),
    .WINDOW(WINDOW), .BUSY(busy_b), .DONE(done_b), .RD_SEL(RD_SEL),
    .RD_DATA(rd_b), .SAT(sat_b)
`ifdef QN_TOGGLE_MON_TOTAL_EN
    , .TOTAL(total_b)
`endif
  );

  typedef struct {
    int tag;
    int sel;
    int e16;
    int e4;
    int s16;
    int s4;
  } rd_exp_t;

  typedef struct {
    int tag;
    int busy;
    int done;
  } scn_exp_t;

  rd_exp_t  rd_q[$];
  scn_exp_t scn_q[$];

  int vectors = 0;
  int miscompares = 0;

  logic rd_req = 1'b0, rd_vld = 1'b0;
  logic scn_req = 1'b0, scn_vld = 1'b0;
  int busy_cnt_a = 0, busy_cnt_b = 0, done_cnt_a = 0, done_cnt_b = 0;

  function automatic void chk(string name, int act, int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endfunction

  // Read data is valid one cycle after the request, so the strobes are pipelined the same way.
  always @(posedge CLK) begin
    rd_vld  <= rd_req;
    scn_vld <= scn_req;
  end

  initial begin
    forever begin
      @(negedge CLK);
      if (rd_vld) begin
        if (rd_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL rd_q underflow: got read with no expectation queued");
        end else begin
          rd_exp_t e;
          e = rd_q.pop_front();
          chk($sformatf("rd t%0d sel%0d data16", e.tag, e.sel), int'(rd_a), e.e16);
          chk($sformatf("rd t%0d sel%0d data4", e.tag, e.sel), int'(rd_b), e.e4);
          chk($sformatf("rd t%0d sel%0d sat16", e.tag, e.sel), int'(sat_a), e.s16);
          chk($sformatf("rd t%0d sel%0d sat4", e.tag, e.sel), int'(sat_b), e.s4);
          $display("read t%0d sel%0d: data16=%0d data4=%0d sat16=%02h sat4=%02h",
                   e.tag, e.sel, rd_a, rd_b, sat_a, sat_b);
        end
      end
      if (scn_vld) begin
        if (scn_q.size() == 0) begin
          vectors++;
          miscompares++;
          $display("FAIL scn_q underflow: got scenario strobe with no expectation queued");
        end else begin
          scn_exp_t s;
          s = scn_q.pop_front();
          chk($sformatf("scn t%0d busy16", s.tag), busy_cnt_a, s.busy);
          chk($sformatf("scn t%0d busy4", s.tag), busy_cnt_b, s.busy);
          chk($sformatf("scn t%0d done16", s.tag), done_cnt_a, s.done);
          chk($sformatf("scn t%0d done4", s.tag), done_cnt_b, s.done);
          $display("scenario t%0d: busy_cycles=%0d/%0d done_pulses=%0d/%0d",
                   s.tag, busy_cnt_a, busy_cnt_b, done_cnt_a, done_cnt_b);
        end
        busy_cnt_a = 0;
        busy_cnt_b = 0;
        done_cnt_a = 0;
        done_cnt_b = 0;
      end
      busy_cnt_a += int'(busy_a);
      busy_cnt_b += int'(busy_b);
      done_cnt_a += int'(done_a);
      done_cnt_b += int'(done_b);
    end
  end

  task automatic tick();
    @(negedge CLK);
  endtask

  task automatic rd(int tag, int sel, int e16, int e4, int s16, int s4);
    rd_exp_t e;
    e.tag = tag; e.sel = sel; e.e16 = e16; e.e4 = e4; e.s16 = s16; e.s4 = s4;
    rd_q.push_back(e);
    RD_SEL = 3'(sel);
    rd_req = 1'b1;
    tick();
    rd_req = 1'b0;
  endtask

  task automatic rd_all(int tag, int hot, int v16, int v4, int s16, int s4);
    for (int s = 0; s < 8; s++) begin
      if (s == hot) rd(tag, s, v16, v4, s16, s4);
      else          rd(tag, s, 0, 0, s16, s4);
    end
  endtask

  task automatic scn_end(int tag, int busy, int done);
    scn_exp_t s;
    s.tag = tag; s.busy = busy; s.done = done;
    scn_q.push_back(s);
    scn_req = 1'b1;
    tick();
    scn_req = 1'b0;
    tick();
  endtask

  task automatic start_win(int win);
    WINDOW = 16'(win);
    START  = 1'b1;
    tick();
    START  = 1'b0;
  endtask

  logic xs [7];

  initial begin
    RSTB = 1'b0; QN_IN = '0; START = 1'b0; ABORT = 1'b0; WINDOW = '0; RD_SEL = '0;
    repeat (3) tick();
    RSTB = 1'b1;
    tick();

    // t0: reset state
    rd_all(0, 0, 0, 0, 0, 0);
    scn_end(0, 0, 0);

    // t1: WINDOW=10, bit0 toggles every cycle
    start_win(10);
    repeat (14) begin QN_IN[0] = ~QN_IN[0]; tick(); end
    rd_all(1, 0, 10, 10, 0, 0);
`ifdef QN_TOGGLE_MON_TOTAL_EN
    chk("total16 t1", int'(total_a), 10);
    chk("total4 t1", int'(total_b), 10);
`endif
    scn_end(1, 11, 1);

    // t2: ABORT in HOLD returns to IDLE keeping counts
    ABORT = 1'b1; tick(); ABORT = 1'b0;
    rd(2, 0, 10, 10, 0, 0);
    scn_end(2, 0, 0);

    // t3: WINDOW=0 completes straight from ARM with cleared counts
    start_win(0);
    repeat (3) tick();
    rd_all(3, 0, 0, 0, 0, 0);
    scn_end(3, 1, 1);

    // t4: 20 toggles on bit3 saturate the 4-bit counter only
    start_win(20);
    repeat (24) begin QN_IN[3] = ~QN_IN[3]; tick(); end
    rd_all(4, 3, 20, 15, 0, 8'h08);
    scn_end(4, 21, 1);

    // t5: restart clears SAT
    start_win(0);
    repeat (3) tick();
    rd(5, 3, 0, 0, 0, 0);
    scn_end(5, 1, 1);

    // t6: ABORT three cycles into an 8-cycle window
    start_win(8);
    repeat (4) begin QN_IN[1] = ~QN_IN[1]; tick(); end
    ABORT = 1'b1; tick(); ABORT = 1'b0;
    repeat (2) tick();
    rd_all(6, 0, 0, 0, 0, 0);
    scn_end(6, 5, 0);

    // t7: START with ABORT from IDLE stays IDLE
    START = 1'b1; ABORT = 1'b1; tick(); START = 1'b0; ABORT = 1'b0;
    repeat (3) tick();
    scn_end(7, 0, 0);

    // t8: X on bit2 for two cycles, two clean toggles
    QN_IN = '0;
    xs = '{1'b0, 1'b1, 1'b0, 1'bx, 1'bx, 1'b0, 1'b0};
    start_win(6);
    for (int k = 0; k < 7; k++) begin QN_IN[2] = xs[k]; tick(); end
    QN_IN[2] = 1'b0;
    repeat (3) tick();
    rd_all(8, 2, 2, 2, 0, 0);
    scn_end(8, 7, 1);

    // t9: asynchronous reset mid-COUNT
    QN_IN = '0; RD_SEL = '0;
    start_win(30);
    repeat (22) begin QN_IN[0] = ~QN_IN[0]; tick(); end
    #2 RSTB = 1'b0;
    #1;
    chk("async rst busy16", int'(busy_a), 0);
    chk("async rst done16", int'(done_a), 0);
    chk("async rst data16", int'(rd_a), 0);
    chk("async rst sat16", int'(sat_a), 0);
    chk("async rst busy4", int'(busy_b), 0);
    chk("async rst done4", int'(done_b), 0);
    chk("async rst data4", int'(rd_b), 0);
    chk("async rst sat4", int'(sat_b), 0);
    $display("async reset: busy=%0d/%0d done=%0d/%0d data=%0d/%0d sat=%02h/%02h",
             busy_a, busy_b, done_a, done_b, rd_a, rd_b, sat_a, sat_b);
    tick();
    RSTB = 1'b1;
    repeat (40) tick();
    rd_all(9, 0, 0, 0, 0, 0);
    scn_end(9, 23, 0);

    repeat (2) tick();
    chk("rd_q drained", rd_q.size(), 0);
    chk("scn_q drained", scn_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
